// File: rtl/serial_four_bit_fs_pkg.sv
// Shared definitions for the bit-serial full subtractor:
// FSM state encoding and bit-counter sizing.
package serial_four_bit_fs_pkg;

  // Controller states. The codes are fixed so that they stay readable on a logic analyser.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fs_state_t;

  // The bit counter must hold the values 0..width (width+1 serial steps).
  function automatic int fs_cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/one_bit_fs.sv
// One-bit full subtractor: computes a - b - bin.
// This is the subtracting counterpart of one_bit_fa.
module one_bit_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit, and the borrow taken from the next more significant bit.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_four_bit_fs.sv
// Bit-serial inverse of the ripple adder. It recovers A = sum - B, LSB first,
// one bit per clock, using a single full subtractor and a borrow flop.
// The start/busy/done handshake follows the upstream adder lab datapath.
module serial_four_bit_fs
  import serial_four_bit_fs_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OUT_W-1:0] sum_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic             underflow,
  output logic             fmt_err
);

  localparam int              CNT_W    = fs_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  fs_state_t        state_reg;
  logic [WIDTH:0]   s_reg;
  logic [WIDTH:0]   b_reg;
  logic [WIDTH:0]   diff_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_out_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             underflow_reg;
  logic             fmt_err_reg;

  logic             d_bit;
  logic             borrow_next;
  logic [WIDTH:0]   diff_next;

  // The single subtractor cell works on the current LSBs of the operand shifters.
  one_bit_fs u_bit (
    .a    (s_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow_reg),
    .d    (d_bit),
    .bout (borrow_next)
  );

  // New difference bits enter at the MSB. After WIDTH+1 steps, the first bit
  // produced (the LSB) has reached bit 0.
  assign diff_next = {d_bit, diff_reg[WIDTH:1]};

  // Controller, datapath shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      s_reg         <= '0;
      b_reg         <= '0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      cnt_reg       <= '0;
      a_out_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      underflow_reg <= 1'b0;
      fmt_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Only the sum bits the adder can legally produce are subtracted.
            // Any upper bits only raise the format flag.
            s_reg         <= sum_in[WIDTH:0];
            b_reg         <= {1'b0, b_in};
            borrow_reg    <= 1'b0;
            cnt_reg       <= '0;
            fmt_err_reg   <= |sum_in[OUT_W-1:WIDTH+1];
            underflow_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_RUN;
          end
        end

        ST_RUN: begin
          s_reg      <= {1'b0, s_reg[WIDTH:1]};
          b_reg      <= {1'b0, b_reg[WIDTH:1]};
          borrow_reg <= borrow_next;
          diff_reg   <= diff_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // A final borrow means the result is negative. A set top bit means
            // the result does not fit in WIDTH bits.
            a_out_reg     <= diff_next[WIDTH-1:0];
            underflow_reg <= borrow_next | diff_next[WIDTH];
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign a_out     = a_out_reg;
  assign underflow = underflow_reg;
  assign fmt_err   = fmt_err_reg;

endmodule

// File: tb/tb_serial_four_bit_fs.sv
// Scoreboard bench for serial_four_bit_fs.
// When an operation is issued, the bench pushes the expected {a, underflow, fmt_err}.
// When the DUT pulses done, the bench pops that entry and compares it.
module tb_serial_four_bit_fs;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] sum_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [3:0] a_out;
  logic       underflow;
  logic       fmt_err;

  typedef struct packed {
    logic [3:0] a;
    logic       uf;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_total;
  int   n_bad;

  serial_four_bit_fs #(.WIDTH(4), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sum_in    (sum_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .a_out     (a_out),
    .underflow (underflow),
    .fmt_err   (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: A = sum[4:0] - B, computed with plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] s, input logic [3:0] b);
    exp_t e;
    int   r;
    r    = int'(s[4:0]) - int'(b);
    e.a  = r[3:0];
    e.uf = (r < 0) || (r > 15);
    e.fe = (s[7:5] != 3'd0);
    return e;
  endfunction

  // Drives a one-cycle start pulse. Returns on the negedge after the accept edge.
  task automatic issue(input logic [7:0] s, input logic [3:0] b, input bit expect_result);
    @(negedge clk);
    sum_in = s;
    b_in   = b;
    start  = 1'b1;
    if (expect_result) exp_q.push_back(model(s, b));
    @(negedge clk);
    start  = 1'b0;
    sum_in = 8'($urandom);
    b_in   = 4'($urandom);
  endtask

  // Waits (bounded) for done.
  // edges:    number of clock edges after the accept edge.
  // busy_cnt: number of sampled cycles with busy high.
  task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
    edges    = 0;
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sum_in = 8'($urandom);
      b_in   = 4'($urandom);
      start  = 1'($urandom);
      #1;
      n_total++;
      if ({busy, done, a_out, underflow, fmt_err} !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_outputs cyc=%0d got busy=%b done=%b a=%h uf=%b fe=%b want all 0",
                 i, busy, done, a_out, underflow, fmt_err);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_start_ignored got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_known;
    logic [7:0] s_tab[4];
    logic [3:0] b_tab[4];
    int         edges;
    int         bcnt;
    bit         ok;
    exp_t       e;
    s_tab = '{8'h0F, 8'h1E, 8'h03, 8'h23};
    b_tab = '{4'd6, 4'hF, 4'd5, 4'd1};
    for (int k = 0; k < 4; k++) begin
      issue(s_tab[k], b_tab[k], 1'b1);
      wait_done(edges, bcnt, ok);
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL known_timeout case=%0d no done within bound", k);
        continue;
      end
      e = exp_q.pop_front();
      if (edges != 5 || bcnt != 5) begin
        n_bad++;
        $display("FAIL known_latency case=%0d got edges=%0d busy=%0d want 5 5", k, edges, bcnt);
      end
      n_total++;
      if (a_out !== e.a || underflow !== e.uf || fmt_err !== e.fe) begin
        n_bad++;
        $display("FAIL known_result case=%0d got a=%h uf=%b fe=%b want a=%h uf=%b fe=%b",
                 k, a_out, underflow, fmt_err, e.a, e.uf, e.fe);
      end
      $display("known case=%0d sum=%h b=%h -> a=%h uf=%b fe=%b",
               k, s_tab[k], b_tab[k], a_out, underflow, fmt_err);
      @(negedge clk);
      n_total++;
      if (done !== 1'b0 || a_out !== e.a || underflow !== e.uf || fmt_err !== e.fe) begin
        n_bad++;
        $display("FAIL known_hold case=%0d got done=%b a=%h uf=%b fe=%b want done=0 a=%h uf=%b fe=%b",
                 k, done, a_out, underflow, fmt_err, e.a, e.uf, e.fe);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   edges;
    int   bcnt;
    bit   ok;
    exp_t e;
    @(negedge clk);
    sum_in = 8'h0F;
    b_in   = 4'd6;
    start  = 1'b1;
    exp_q.push_back(model(8'h0F, 4'd6));
    @(negedge clk);
    wait_done(edges, bcnt, ok);
    n_total++;
    if (!ok || edges != 5) begin
      n_bad++;
      $display("FAIL b2b_first_done got ok=%0d edges=%0d want 1 5", ok, edges);
    end
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (a_out !== e.a || underflow !== e.uf) begin
        n_bad++;
        $display("FAIL b2b_first_result got a=%h uf=%b want a=%h uf=%b", a_out, underflow, e.a, e.uf);
      end
    end
    exp_q.push_back(model(8'h0F, 4'd6));
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle_gap got busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_reaccept got busy=%b want 1", busy);
    end
    wait_done(edges, bcnt, ok);
    n_total++;
    if (!ok || edges != 5) begin
      n_bad++;
      $display("FAIL b2b_second_done got ok=%0d edges=%0d want 1 5", ok, edges);
    end
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (a_out !== e.a || underflow !== e.uf || fmt_err !== e.fe) begin
        n_bad++;
        $display("FAIL b2b_second_result got a=%h uf=%b fe=%b want a=%h uf=%b fe=%b",
                 a_out, underflow, fmt_err, e.a, e.uf, e.fe);
      end
    end
    $display("b2b two results a=%h uf=%b", a_out, underflow);
  endtask

  task automatic test_reset_mid_run;
    int   edges;
    int   bcnt;
    bit   ok;
    bit   seen_done;
    exp_t e;
    issue(8'h1E, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, a_out, underflow, fmt_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL midrun_reset got busy=%b done=%b a=%h uf=%b fe=%b want all 0",
               busy, done, a_out, underflow, fmt_err);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_total++;
    if (seen_done) begin
      n_bad++;
      $display("FAIL midrun_no_done got done pulse want none");
    end
    issue(8'h0F, 4'd6, 1'b1);
    wait_done(edges, bcnt, ok);
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midrun_restart_timeout no done within bound");
    end else begin
      e = exp_q.pop_front();
      if (a_out !== e.a || underflow !== e.uf || fmt_err !== e.fe) begin
        n_bad++;
        $display("FAIL midrun_restart got a=%h uf=%b fe=%b want a=%h uf=%b fe=%b",
                 a_out, underflow, fmt_err, e.a, e.uf, e.fe);
      end
    end
    $display("midrun restart a=%h uf=%b", a_out, underflow);
  endtask

  task automatic test_sweep;
    int         edges;
    int         bcnt;
    bit         ok;
    exp_t       e;
    logic [7:0] s;
    int         sweep_bad;
    sweep_bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        s = 8'(a + b);
        issue(s, 4'(b), 1'b1);
        wait_done(edges, bcnt, ok);
        n_total++;
        if (!ok) begin
          n_bad++;
          sweep_bad++;
          $display("FAIL sweep_timeout a=%0d b=%0d", a, b);
          void'(exp_q.pop_front());
          continue;
        end
        e = exp_q.pop_front();
        if (a_out !== e.a || underflow !== e.uf || a_out !== 4'(a) || underflow !== 1'b0) begin
          n_bad++;
          sweep_bad++;
          $display("FAIL sweep a=%0d b=%0d got a_out=%h uf=%b want a_out=%h uf=0",
                   a, b, a_out, underflow, 4'(a));
        end
      end
    end
    $display("sweep 256 pairs errors=%0d", sweep_bad);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    start   = 1'b0;
    sum_in  = 8'h00;
    b_in    = 4'h0;
    rst_n   = 1'b0;
    test_reset();
    test_known();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
